// File: rtl/ps2_scancode_tracker.sv
// PS/2 scan-code tracker: pops bytes from the receiver FIFO, decodes make/break/E0
// sequences and keeps the last key, its ASCII value, a held flag and a BCD press count.
module ps2_scancode_tracker #(
    parameter bit IGNORE_REPEAT  = 1'b1,
    parameter int PREFIX_TIMEOUT = 5_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_ready,
    input  logic       ps2_overflow,
    output logic       ps2_pop,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic [7:0] key_ascii,
    output logic       key_down,
    output logic [7:0] press_count,
    output logic       overflow_seen
);
    localparam int CW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(PREFIX_TIMEOUT - 1);
    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BRK = 8'hF0;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} state_t;

    state_t          state_q, state_d;
    logic            pop_q, pop_d;
    logic [7:0]      byte_q, byte_d;
    logic [CW-1:0]   tmo_q, tmo_d;
    logic [7:0]      key_code_q, key_code_d;
    logic            key_ext_q, key_ext_d;
    logic [7:0]      key_ascii_q, key_ascii_d;
    logic            key_down_q, key_down_d;
    logic [7:0]      press_count_q, press_count_d;
    logic            overflow_seen_q, overflow_seen_d;

    logic fetch, decode, tmo_hit, is_prefix;
    logic is_make, is_break, ev_ext, same_key;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // Set-2 make codes to ASCII, non-extended keys only
    function automatic logic [7:0] ascii_lut(input logic [7:0] b);
        case (b)
            8'h1C: ascii_lut = 8'h61;  8'h32: ascii_lut = 8'h62;
            8'h21: ascii_lut = 8'h63;  8'h23: ascii_lut = 8'h64;
            8'h24: ascii_lut = 8'h65;  8'h2B: ascii_lut = 8'h66;
            8'h34: ascii_lut = 8'h67;  8'h33: ascii_lut = 8'h68;
            8'h43: ascii_lut = 8'h69;  8'h3B: ascii_lut = 8'h6A;
            8'h42: ascii_lut = 8'h6B;  8'h4B: ascii_lut = 8'h6C;
            8'h3A: ascii_lut = 8'h6D;  8'h31: ascii_lut = 8'h6E;
            8'h44: ascii_lut = 8'h6F;  8'h4D: ascii_lut = 8'h70;
            8'h15: ascii_lut = 8'h71;  8'h2D: ascii_lut = 8'h72;
            8'h1B: ascii_lut = 8'h73;  8'h2C: ascii_lut = 8'h74;
            8'h3C: ascii_lut = 8'h75;  8'h2A: ascii_lut = 8'h76;
            8'h1D: ascii_lut = 8'h77;  8'h22: ascii_lut = 8'h78;
            8'h35: ascii_lut = 8'h79;  8'h1A: ascii_lut = 8'h7A;
            8'h45: ascii_lut = 8'h30;  8'h16: ascii_lut = 8'h31;
            8'h1E: ascii_lut = 8'h32;  8'h26: ascii_lut = 8'h33;
            8'h25: ascii_lut = 8'h34;  8'h2E: ascii_lut = 8'h35;
            8'h36: ascii_lut = 8'h36;  8'h3D: ascii_lut = 8'h37;
            8'h3E: ascii_lut = 8'h38;  8'h46: ascii_lut = 8'h39;
            8'h29: ascii_lut = 8'h20;  8'h5A: ascii_lut = 8'h0D;
            default: ascii_lut = 8'h00;
        endcase
    endfunction

    // The byte fetched at one edge is decoded at the next; pop_q marks that decode cycle
    assign fetch     = ps2_ready && !pop_q;
    assign decode    = pop_q;
    assign is_prefix = (byte_q == B_EXT) || (byte_q == B_BRK);
    assign tmo_hit   = (state_q != S_IDLE) && !fetch && (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            pop_q           <= 1'b0;
            byte_q          <= 8'h00;
            tmo_q           <= '0;
            key_code_q      <= 8'h00;
            key_ext_q       <= 1'b0;
            key_ascii_q     <= 8'h00;
            key_down_q      <= 1'b0;
            press_count_q   <= 8'h00;
            overflow_seen_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pop_q           <= pop_d;
            byte_q          <= byte_d;
            tmo_q           <= tmo_d;
            key_code_q      <= key_code_d;
            key_ext_q       <= key_ext_d;
            key_ascii_q     <= key_ascii_d;
            key_down_q      <= key_down_d;
            press_count_q   <= press_count_d;
            overflow_seen_q <= overflow_seen_d;
        end
    end

    // Next-state logic; a decode on the expiry edge takes priority over the timeout
    always_comb begin
        state_d = state_q;
        if (decode) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_q == B_EXT)      state_d = S_EXT;
                    else if (byte_q == B_BRK) state_d = S_BRK;
                    else                      state_d = S_IDLE;
                end
                S_EXT: begin
                    if (byte_q == B_BRK)      state_d = S_EXTBRK;
                    else if (byte_q == B_EXT) state_d = S_EXT;
                    else                      state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = S_IDLE;
        end
    end

    // Output / datapath logic
    always_comb begin
        pop_d           = fetch;
        byte_d          = fetch ? ps2_byte : byte_q;
        tmo_d           = (fetch || decode || tmo_hit || state_q == S_IDLE) ? '0 : tmo_q + CW'(1);
        key_code_d      = key_code_q;
        key_ext_d       = key_ext_q;
        key_ascii_d     = key_ascii_q;
        key_down_d      = key_down_q;
        press_count_d   = press_count_q;
        overflow_seen_d = overflow_seen_q | ps2_overflow;

        is_make  = decode && !is_prefix && (state_q == S_IDLE || state_q == S_EXT);
        is_break = decode && (state_q == S_BRK || state_q == S_EXTBRK);
        ev_ext   = (state_q == S_EXT) || (state_q == S_EXTBRK);
        same_key = (byte_q == key_code_q) && (ev_ext == key_ext_q);

        if (is_make) begin
            if (key_down_q && same_key) begin
                if (!IGNORE_REPEAT) press_count_d = bcd_inc(press_count_q);
            end else begin
                key_code_d    = byte_q;
                key_ext_d     = ev_ext;
                key_down_d    = 1'b1;
                key_ascii_d   = ev_ext ? 8'h00 : ascii_lut(byte_q);
                press_count_d = bcd_inc(press_count_q);
            end
        end
        if (is_break && same_key) key_down_d = 1'b0;
    end

    assign ps2_pop       = pop_q;
    assign key_code      = key_code_q;
    assign key_ext       = key_ext_q;
    assign key_ascii     = key_ascii_q;
    assign key_down      = key_down_q;
    assign press_count   = press_count_q;
    assign overflow_seen = overflow_seen_q;
endmodule
